// File: rtl/lsu_wb_fifo.sv
// lsu_wb_fifo: in-order result buffer between the LSU/DCache response path and the CDB writeback arbiter.
// Optional same-cycle empty-buffer bypass is enabled by defining LSU_WB_BYPASS_EN.
module lsu_wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ID_W   = 6,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ID_W-1:0]   in_preg_i,
    input  logic              in_wreg_i,
    input  logic              in_inst_valid_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ID_W-1:0]   out_preg_o,
    output logic              out_wreg_o,
    output logic              out_inst_valid_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   preg;
        logic              wreg;
        logic              inst_valid;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           in_ent;
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             bypass;

    assign empty  = (cnt == '0);
    assign full   = (cnt == CNT_W'(DEPTH));
    assign in_ent = '{data: in_data_i, preg: in_preg_i, wreg: in_wreg_i, inst_valid: in_inst_valid_i};

`ifdef LSU_WB_BYPASS_EN
    // Empty buffer with a ready consumer: hand the result straight through, no storage touched.
    assign bypass = empty & in_valid_i & out_ready_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    // Ready depends on registered occupancy only, so a pop never opens a slot in the same cycle.
    assign in_ready_o = ~full;
    assign push       = in_valid_i & in_ready_o & ~bypass;
    assign pop        = ~empty & out_ready_i;

    assign head             = bypass ? in_ent : mem[rd_ptr];
    assign out_valid_o      = ~empty | bypass;
    assign out_data_o       = head.data;
    assign out_preg_o       = head.preg;
    assign out_wreg_o       = head.wreg;
    assign out_inst_valid_o = head.inst_valid;
    assign count_o          = cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && push) mem[wr_ptr] <= in_ent;
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n || flush_i)
                                     !(push && !pop && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n || flush_i)
                                     !(pop && !push && empty));

endmodule

// File: tb/tb_lsu_wb_fifo.sv
// Scoreboard bench for lsu_wb_fifo: directed scenarios followed by randomized traffic with flushes.
module tb_lsu_wb_fifo;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ID_W   = 6;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PW     = DATA_W + ID_W + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic [ID_W-1:0]   in_preg_i;
    logic              in_wreg_i;
    logic              in_inst_valid_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [ID_W-1:0]   out_preg_o;
    logic              out_wreg_o;
    logic              out_inst_valid_o;
    logic [CNT_W-1:0]  count_o;

    always #5 clk = ~clk;

    lsu_wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .in_preg_i(in_preg_i), .in_wreg_i(in_wreg_i), .in_inst_valid_i(in_inst_valid_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_preg_o(out_preg_o), .out_wreg_o(out_wreg_o), .out_inst_valid_o(out_inst_valid_o),
        .count_o(count_o)
    );

    int             checks   = 0;
    int             failures = 0;
    int             sz;
    logic           exp_ov;
    logic [PW-1:0]  exp_q[$];
    logic [PW-1:0]  act_pl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted results, capacity DEPTH, cleared by flush.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            sz = exp_q.size();
            chk("count", 64'(count_o), 64'(sz));
            chk("in_ready", 64'(in_ready_o), 64'(sz != DEPTH));
            exp_ov = (sz != 0);
`ifdef LSU_WB_BYPASS_EN
            if (sz == 0 && in_valid_i && out_ready_i && !flush_i) exp_ov = 1'b1;
`endif
            chk("out_valid", 64'(out_valid_o), 64'(exp_ov));
            if (flush_i) begin
                exp_q.delete();
            end else begin
                if (in_valid_i && sz != DEPTH)
                    exp_q.push_back({in_data_i, in_preg_i, in_wreg_i, in_inst_valid_i});
                if (out_valid_o) begin
                    act_pl = {out_data_o, out_preg_o, out_wreg_o, out_inst_valid_o};
                    if (exp_q.size() == 0) begin
                        chk("spurious_out", 64'(out_valid_o), 64'd0);
                    end else begin
                        chk("payload", 64'(act_pl), 64'(exp_q[0]));
                        if (out_ready_i) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [ID_W-1:0] p,
                         input logic rdy, input logic fl);
        in_valid_i      = v;
        in_data_i       = d;
        in_preg_i       = p;
        in_wreg_i       = d[0];
        in_inst_valid_i = ~d[1];
        out_ready_i     = rdy;
        flush_i         = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) drive(0, '0, '0, 0, 0);
        rst_n = 1'b1;
        repeat (5) drive(0, '0, '0, 0, 0);

        // fill to full, fifth result refused, then drain in order
        for (int i = 1; i <= 4; i++) drive(1, DATA_W'(32'h11 * i), ID_W'(i), 0, 0);
        drive(1, 32'h55, 6'd5, 0, 0);
        repeat (4) drive(0, '0, '0, 1, 0);
        repeat (2) drive(0, '0, '0, 0, 0);

        // steady streaming, pointers wrap several times
        for (int i = 0; i < 16; i++) drive(1, DATA_W'(32'h100 + i), ID_W'(i), 1, 0);
        repeat (2) drive(0, '0, '0, 1, 0);

        // full with simultaneous pop: push refused, accepted next cycle
        for (int i = 0; i < 4; i++) drive(1, DATA_W'(32'h200 + i), ID_W'(i), 0, 0);
        drive(1, 32'h2A0, 6'd9, 1, 0);
        drive(1, 32'h2A1, 6'd10, 0, 0);
        repeat (5) drive(0, '0, '0, 1, 0);

        // flush with three entries and a concurrent input
        for (int i = 0; i < 3; i++) drive(1, DATA_W'(32'h300 + i), ID_W'(i), 0, 0);
        drive(1, 32'hBAD, 6'd11, 0, 1);
        repeat (2) drive(0, '0, '0, 1, 0);
        drive(1, 32'h400, 6'd12, 1, 0);
        repeat (2) drive(0, '0, '0, 1, 0);

        // backpressure hold on head while two more results arrive
        drive(1, 32'hDEADBEEF, 6'd7, 0, 0);
        drive(1, 32'h501, 6'd8, 0, 0);
        drive(1, 32'h502, 6'd9, 0, 0);
        repeat (3) drive(0, '0, '0, 0, 0);
        repeat (4) drive(0, '0, '0, 1, 0);

        // randomized traffic with occasional flushes
        repeat (400)
            drive($urandom_range(0, 3) != 0, DATA_W'($urandom), ID_W'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        repeat (6) drive(0, '0, '0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
